// File: rtl/multdiv_sequencer_if.sv
// Bundle between EXE, the HI/LO sequencer and the multiply/divide cores.
// master: the sequencer; slave: EXE plus the datapath cores.
interface multdiv_sequencer_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ex_hold;
    logic        flush;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_prod;
    logic        div_req_valid;
    logic        div_req_ready;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_resp_valid;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_o;
    logic        busy_o;

    modport master (
        input  op_valid, op_code, op_a, op_b, ex_hold, flush,
        input  mul_prod, div_req_ready,
        input  div_resp_valid, div_quot, div_rem,
        output mul_start, mul_signed, mul_a, mul_b,
        output div_req_valid, div_signed,
        output div_dividend, div_divisor,
        output hi_o, lo_o, stall_o, busy_o
    );

    modport slave (
        output op_valid, op_code, op_a, op_b, ex_hold, flush,
        output mul_prod, div_req_ready,
        output div_resp_valid, div_quot, div_rem,
        input  mul_start, mul_signed, mul_a, mul_b,
        input  div_req_valid, div_signed,
        input  div_dividend, div_divisor,
        input  hi_o, lo_o, stall_o, busy_o
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// HI/LO sequencer: launches the multiplier or divider core, owns HI/LO,
// stalls EXE until commit and drains divides killed by a flush.
module multdiv_sequencer #(
    parameter int unsigned MUL_LAT = 2
) (
    input logic                 clk,
    input logic                 rst,
    multdiv_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_REQ,
        DIV_WAIT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(MUL_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic        dsg_q;

    logic is_mul;
    logic is_div;
    logic is_mt;
    logic accept;
    logic hs;
    logic mul_done;
    logic mul_commit;
    logic div_commit;
    logic commit;
    logic md_op;
    logic wait_st;

    assign is_mul     = (bus.op_code == 3'd0) || (bus.op_code == 3'd1);
    assign is_div     = (bus.op_code == 3'd2) || (bus.op_code == 3'd3);
    assign is_mt      = (bus.op_code == 3'd4) || (bus.op_code == 3'd5);
    assign accept     = (state == IDLE) && bus.op_valid && !bus.flush;
    assign hs         = (state == DIV_REQ) && bus.div_req_ready;
    assign mul_done   = (state == MUL_WAIT) && (cnt == LAT);
    assign mul_commit = mul_done && !bus.flush;
    assign div_commit = (state == DIV_WAIT) && bus.div_resp_valid
                        && !bus.flush;
    assign commit     = mul_commit || div_commit;
    assign md_op      = bus.op_valid && (is_mul || is_div) && !bus.flush;
    assign wait_st    = (state == IDLE) || (state == MUL_WAIT)
                        || (state == DIV_REQ) || (state == DIV_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && is_mul)      state_nxt = MUL_WAIT;
                else if (accept && is_div) state_nxt = DIV_REQ;
            end
            MUL_WAIT: begin
                if (bus.flush)    state_nxt = IDLE;
                else if (mul_done) state_nxt = bus.ex_hold ? DONE : IDLE;
            end
            DIV_REQ: begin
                if (hs)             state_nxt = bus.flush ? DRAIN : DIV_WAIT;
                else if (bus.flush) state_nxt = IDLE;
            end
            DIV_WAIT: begin
                if (bus.flush)
                    state_nxt = bus.div_resp_valid ? IDLE : DRAIN;
                else if (bus.div_resp_valid)
                    state_nxt = bus.ex_hold ? DONE : IDLE;
            end
            // The killed divide must still retire from the core.
            DRAIN: begin
                if (bus.div_resp_valid) state_nxt = IDLE;
            end
            DONE: begin
                if (bus.flush || !bus.ex_hold) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mul_start     = 1'b0;
        bus.mul_signed    = 1'b0;
        bus.mul_a         = '0;
        bus.mul_b         = '0;
        bus.div_req_valid = (state == DIV_REQ);
        bus.busy_o        = (state != IDLE);
        bus.stall_o       = (md_op && ((wait_st && !commit)
                            || (state == DRAIN)))
                            || (bus.op_valid && is_mt && (state == DRAIN));
        if (accept && is_mul) begin
            bus.mul_start  = 1'b1;
            bus.mul_signed = (bus.op_code == 3'd0);
            bus.mul_a      = bus.op_a;
            bus.mul_b      = bus.op_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     cnt <= '0;
        else if (accept && is_mul)    cnt <= 3'd1;
        else if (state_nxt == MUL_WAIT) cnt <= cnt + 3'd1;
        else                          cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            dsg_q <= 1'b0;
        end else if (accept && is_div) begin
            dvd_q <= bus.op_a;
            dvs_q <= bus.op_b;
            dsg_q <= (bus.op_code == 3'd2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            unique case (1'b1)
                mul_commit: begin
                    hi_q <= bus.mul_prod[63:32];
                    lo_q <= bus.mul_prod[31:0];
                end
                div_commit: begin
                    hi_q <= bus.div_rem;
                    lo_q <= bus.div_quot;
                end
                (accept && bus.op_code == 3'd4): hi_q <= bus.op_a;
                (accept && bus.op_code == 3'd5): lo_q <= bus.op_a;
                default: ;
            endcase
        end
    end

    assign bus.div_signed   = dsg_q;
    assign bus.div_dividend = dvd_q;
    assign bus.div_divisor  = dvs_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;

endmodule
